// File: rtl/mux7_rr_arbiter.sv
// mux7_rr_arbiter: round-robin owner of a shared 7:1 32-bit mux, with a bounded hold time
module mux7_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] req,
    output logic [6:0] grant,
    output logic [2:0] select,
    output logic       busy,
    output logic       preempt
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [6:0]       grant_q, grant_d, others;
    logic [2:0]       sel_q, sel_d, ptr_q, ptr_d, nxt, win;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pre_q, pre_d, hold_hit, forced, rel;

    // First set bit of m, scanning upward from s and wrapping at 7.
    function automatic logic [2:0] rr_pick(input logic [6:0] m, input logic [2:0] s);
        logic [2:0] w;
        logic [3:0] t;
        w = '0;
        for (int k = 6; k >= 0; k--) begin
            t = {1'b0, s} + 4'(k);
            if (t >= 4'd7) t = t - 4'd7;
            if (m[t[2:0]]) w = t[2:0];
        end
        return w;
    endfunction

    always_comb begin
        hold_hit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));
        forced   = hold_hit && req[sel_q];
        rel      = !req[sel_q] || hold_hit;
        others   = req & ~grant_q;
        nxt      = (sel_q == 3'd6) ? 3'd0 : sel_q + 3'd1;
        win      = rr_pick(others, (state_q == IDLE) ? ptr_q : nxt);
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        pre_d    = 1'b0;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                grant_d = 7'b1 << win;
                sel_d   = win;
                cnt_d   = CNT_W'(1);
            end
        end else if (!rel) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            ptr_d = nxt;
            pre_d = forced;
            cnt_d = CNT_W'(1);
            if (|others) begin
                grant_d = 7'b1 << win;
                sel_d   = win;
            end else if (!forced) begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    assign grant   = grant_q;
    assign select  = sel_q;
    assign busy    = |grant_q;
    assign preempt = pre_q;
endmodule

// File: doc/mux7_rr_arbiter.md
Name: mux7_rr_arbiter

Overview:
- Round-robin arbiter that shares one 7:1 32-bit datapath mux between seven requesters.
- Produces the mux 3-bit select plus a one-hot grant.
- Holds ownership across multi-cycle transfers and forces re-arbitration after a bounded hold time.
- Sits beside the shared-bus mux and drives its select directly; select value 3'b111 is never produced.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per ownership. 0 disables the limit.
- CNT_W, 5: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  7  request per requester. Bit i maps to mux input Ii.
- grant  output  7  one-hot grant, registered. All-zero when idle.
- select  output  3  mux select (index of current owner), registered.
- busy  output  1  high while any grant is asserted.
- preempt  output  1  one-cycle pulse on the cycle after a MAX_HOLD forced release.

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - grant=7'b0, select=3'b000, busy=0, preempt=0.
  - Round-robin pointer ptr=0; hold counter cnt=0; state=IDLE.
- State IDLE:
  - If req != 0 at a rising edge, take the winner = first set req bit scanning ptr, ptr+1, ... 6, 0, ... (wrap modulo 7).
  - On that edge: grant = one-hot(winner), select = winner, busy=1, cnt=1, state=GRANT.
  - Latency: req high before edge N gives grant visible after edge N.
  - If req == 0: stay IDLE. select keeps its last value (no glitch on the mux).
- State GRANT, owner o:
  - Release condition at an edge: req[o]==0, OR (MAX_HOLD!=0 AND cnt==MAX_HOLD).
  - No release: hold grant/select; cnt=cnt+1, saturating at MAX_HOLD.
  - On release: ptr = (o+1) mod 7. Then:
    - If any other req bit (excluding o) is set: grant passes directly to the next winner, scanning from the new ptr, on the same edge. No idle bubble; cnt=1.
    - Forced release with only req[o] set: o is re-granted; cnt=1.
    - Voluntary release with no other req: grant=0, busy=0, state=IDLE.
- preempt:
  - Asserted for exactly one cycle after any edge where release was caused by cnt==MAX_HOLD while req[o] was still 1. This includes the re-grant-to-self case.
  - 0 otherwise.
- Invariants: grant is always 0 or one-hot; busy == |grant; when busy=1, select == index of the set grant bit.
- req bits of non-owners changing during GRANT have no effect until release.
- Owner dropping req on the same edge another requester rises is a normal back-to-back handoff.

Test Plan:
- Reset, then req=7'b0000100 → one edge later grant=7'b0000100, select=3'd2, busy=1. Assert reset mid-grant → grant=0, select=0, busy=0 immediately, without waiting for a clock edge.
- req=7'b1111111 held, MAX_HOLD=16 → owners 0,1,2,3,4,5,6,0 in turn, each for exactly 16 cycles. preempt pulses at each switch; select never reaches 3'b111.
- req=7'b0001001; owner 0 drops req after 3 cycles → grant moves to bit 3 on the next edge with no idle cycle. ptr then favours 4 over 0.
- Only req[5] held for 40 cycles, MAX_HOLD=16 → grant stays 7'b0100000 throughout, cnt restarts, preempt pulses after cycles 16 and 32.
- Owner 6 releases with req=7'b0000001 pending → grant wraps to bit 0 (select=0). Then req=0 → grant=0, busy=0, select stays 0.
- MAX_HOLD=0, req[1] held for 100 cycles while req[4] is high → bit 1 keeps the grant, preempt never asserts. Drop req[1] → grant to bit 4 next edge.
